// File: rtl/mul_div_sequencer.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned restoring divide.
// Drives one external adder_subtractor and registers its result each RUN cycle.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one multiply/divide bit per cycle, 8 cycles
// DONE  | one-cycle done pulse, results valid
module mul_div_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_subtract,
    input  logic [WIDTH-1:0] add_r,
    input  logic             add_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] h, l, m;
    logic [2:0]       cnt;
    logic             op_q;
    logic             dbz_start;
    logic [WIDTH-1:0] div_s;
    logic             div_qb;

    // A divide with a zero divisor skips RUN and reports straight away.
    assign dbz_start = op && (b_in == '0);

    // Divide: shift the next dividend bit into the partial remainder; H[7] is
    // the ninth remainder bit, so a set H[7] always means the subtract fits.
    assign div_s  = {h[WIDTH-2:0], l[WIDTH-1]};
    assign div_qb = h[WIDTH-1] | add_carry;

    assign result_hi = h;
    assign result_lo = l;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, status outputs and adder drive from registered state.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        add_a        = '0;
        add_b        = '0;
        add_subtract = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = dbz_start ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (op_q) begin
                    add_a        = div_s;
                    add_b        = m;
                    add_subtract = 1'b1;
                end else begin
                    add_a = h;
                    add_b = l[0] ? m : '0;
                end
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand load on an accepted start, then one iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= '0;
            l           <= '0;
            m           <= '0;
            cnt         <= '0;
            op_q        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m    <= b_in;
                        cnt  <= '0;
                        op_q <= op;
                        if (dbz_start) begin
                            h           <= a_in;
                            l           <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            h           <= '0;
                            l           <= a_in;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 3'd1;
                    if (op_q) begin
                        h <= div_qb ? add_r : div_s;
                        l <= {l[WIDTH-2:0], div_qb};
                    end else begin
                        h <= {add_carry, add_r[WIDTH-1:1]};
                        l <= {add_r[0], l[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: models the external adder_subtractor,
// queues expected results at start, and compares them when done pulses.
module tb_mul_div_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       div_by_zero;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_subtract;
    logic [7:0] add_r;
    logic       add_carry;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dbz;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mul_div_sequencer #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy         (busy),
        .done         (done),
        .result_hi    (result_hi),
        .result_lo    (result_lo),
        .div_by_zero  (div_by_zero),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_subtract (add_subtract),
        .add_r        (add_r),
        .add_carry    (add_carry)
    );

    // External adder_subtractor: subtract is a + ~b + 1, carry=1 means no borrow.
    assign {add_carry, add_r} = add_subtract ?
        ({1'b0, add_a} + {1'b0, ~add_b} + 9'd1) :
        ({1'b0, add_a} + {1'b0, add_b});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_hi", 32'(result_hi), 32'(e.hi));
                chk("result_lo", 32'(result_lo), 32'(e.lo));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    function automatic exp_t model(input logic o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [15:0] p;
        if (!o) begin
            p     = 16'(a) * 16'(b);
            e.hi  = p[15:8];
            e.lo  = p[7:0];
            e.dbz = 1'b0;
        end else if (b == 8'd0) begin
            e.hi  = a;
            e.lo  = 8'hFF;
            e.dbz = 1'b1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Start one operation, optionally poke start mid-RUN, check latency and busy width.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input bit poke);
        int n;
        int busy_n;
        int lat;
        lat = (o && b == 8'd0) ? 1 : 9;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        exp_q.push_back(model(o, a, b));
        n      = 0;
        busy_n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_n++;
            if (n == 1) begin
                start = 1'b0;
                a_in  = ~a;
                b_in  = b + 8'd3;
                op    = ~o;
            end
            if (poke && n == 3) start = 1'b1;
            if (poke && n == 4) start = 1'b0;
        end while (!done && n < 20);
        chk("latency", 32'(n), 32'(lat));
        chk("busy_cycles", 32'(busy_n), 32'(lat - 1));
        @(posedge clk);
        #1;
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("idle_add_a", 32'(add_a), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        #23;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'({result_hi, result_lo}), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_adder", 32'({add_a, add_b, add_subtract}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 8'd13, 8'd11, 1'b0);
        run_op(1'b0, 8'd255, 8'd255, 1'b0);
        run_op(1'b0, 8'd0, 8'd200, 1'b0);
        run_op(1'b1, 8'd200, 8'd7, 1'b0);
        run_op(1'b1, 8'd255, 8'd1, 1'b0);
        run_op(1'b1, 8'd250, 8'd200, 1'b0);
        run_op(1'b1, 8'h5A, 8'd0, 1'b0);
        // Back-to-back: mul follows the divide-by-zero, div follows the mul;
        // the mul clears div_by_zero.
        run_op(1'b0, 8'd77, 8'd3, 1'b0);
        run_op(1'b1, 8'd99, 8'd10, 1'b0);
        // Start pulsed during RUN with different operands must be ignored.
        run_op(1'b0, 8'd21, 8'd12, 1'b1);
        run_op(1'b1, 8'd143, 8'd13, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(1, 255)), 1'b0);
        end

        // Async reset in RUN cycle 4 after a divide-by-zero left status set.
        run_op(1'b1, 8'h33, 8'd0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a_in  = 8'd100;
        b_in  = 8'd3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'({result_hi, result_lo}), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done), 32'd0);
        run_op(1'b0, 8'd100, 8'd3, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
